// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - fetch FSM state encoding (2 bits)
//   - default reset PC
//   - next-PC source select encoding plus the priority decode that picks it
// Opcode values remain in instructions_define.vh; nothing here depends on them.
package instr_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DECODE = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,  // pc + 4
        NPC_BRANCH = 2'd1,  // pc + 4 + sign-extended word offset
        NPC_JUMP   = 2'd2,  // 26-bit region jump (j / jal)
        NPC_JR     = 2'd3   // register target
    } npc_src_e;

    // jal also raises nPC_sel, so the jump selects must outrank the branch.
    function automatic npc_src_e npc_select(input logic jr, input logic j,
                                            input logic jal, input logic npc_sel,
                                            input logic br_taken);
        if (jr)                      return NPC_JR;
        else if (j || jal)           return NPC_JUMP;
        else if (npc_sel && br_taken) return NPC_BRANCH;
        else                         return NPC_SEQ;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Combinational next-PC calculation for the instruction in IR.
// Ports:
//   pc_plus4   in   AW  sequential successor of the current pc
//   target     in   26  ir[25:0]; low 16 bits double as the branch immediate
//   nPC_sel    in   1   branch/jump PC select from the decoder
//   J, jal, jr in   1   jump-type selects
//   br_taken   in   1   ALU branch condition
//   rs_data    in   32  jr target
//   npc        out  AW  next pc (modulo 2^AW)
//   misalign   out  1   jr target had nonzero low bits (they are forced to 0)
module instr_fetch_unit_npc_calc
    import instr_fetch_unit_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] pc_plus4,
    input  logic [25:0]   target,
    input  logic          nPC_sel,
    input  logic          J,
    input  logic          jal,
    input  logic          jr,
    input  logic          br_taken,
    input  logic [31:0]   rs_data,
    output logic [AW-1:0] npc,
    output logic          misalign
);

    npc_src_e          src;
    logic signed [31:0] br_off;

    assign src      = npc_select(jr, J, jal, nPC_sel, br_taken);
    assign br_off   = {{14{target[15]}}, target[15:0], 2'b00};
    assign misalign = jr && (rs_data[1:0] != 2'b00);

    always_comb begin
        npc = pc_plus4;
        case (src)
            NPC_JR:     npc = AW'({rs_data[31:2], 2'b00});
            NPC_JUMP:   npc = {pc_plus4[AW-1:28], target, 2'b00};
            NPC_BRANCH: npc = pc_plus4 + AW'(br_off);
            default:    npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory, latches IR for the
// decoder and advances the PC when the datapath commits.
// One instruction in flight; memory latency is unbounded.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   imem_req/addr     read request (held until imem_ready) and address (= pc)
//   imem_ready/rdata  response strobe and instruction word
//   ir, ir_valid, pc  latched instruction, its validity and its address
//   pc_plus4          pc + 4 (jal link value), combinational
//   commit            datapath finished the instruction in ir
//   nPC_sel, J, jal, jr, br_taken, rs_data   next-pc controls
//   misalign          1-cycle pulse when a committed jr target was unaligned
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          AW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ready,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   ir,
    output logic          ir_valid,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_plus4,
    input  logic          commit,
    input  logic          nPC_sel,
    input  logic          J,
    input  logic          jal,
    input  logic          jr,
    input  logic          br_taken,
    input  logic [31:0]   rs_data,
    output logic          misalign
);

    fetch_state_e  state;
    logic [AW-1:0] npc;
    logic          npc_misalign;

    assign pc_plus4  = pc + AW'(4);
    assign imem_addr = pc;

    instr_fetch_unit_npc_calc #(.AW(AW)) u_npc (
        .pc_plus4 (pc_plus4),
        .target   (ir[25:0]),
        .nPC_sel  (nPC_sel),
        .J        (J),
        .jal      (jal),
        .jr       (jr),
        .br_taken (br_taken),
        .rs_data  (rs_data),
        .npc      (npc),
        .misalign (npc_misalign)
    );

    // imem_req is a registered output. Out of reset it rises one cycle after
    // FETCH is entered; after a commit it is raised together with the pc
    // update, so the next request appears the cycle after commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc       <= AW'(RESET_PC);
            ir       <= '0;
            ir_valid <= 1'b0;
            imem_req <= 1'b0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                ST_FETCH, ST_WAIT: begin
                    if (imem_req && imem_ready) begin
                        ir       <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= ST_DECODE;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= imem_req ? ST_WAIT : ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (commit) begin
                        pc       <= npc;
                        ir_valid <= 1'b0;
                        imem_req <= 1'b1;
                        misalign <= npc_misalign;
                        state    <= ST_FETCH;
                    end
                end
                default: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction
// level model (pc, ir, valid, request pending) kept here.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] W_ADDU = 32'h0085_1021;
    localparam logic [31:0] W_BEQ  = 32'h1000_FFFF;
    localparam logic [31:0] W_JAL  = 32'h0C00_0C10;
    localparam logic [31:0] W_JR   = 32'h0080_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit = 1'b0;
    logic        nPC_sel = 1'b0, J = 1'b0, jal = 1'b0, jr = 1'b0, br_taken = 1'b0;
    logic [31:0] rs_data = '0;
    logic        misalign;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir(ir), .ir_valid(ir_valid), .pc(pc), .pc_plus4(pc_plus4),
        .commit(commit), .nPC_sel(nPC_sel), .J(J), .jal(jal), .jr(jr),
        .br_taken(br_taken), .rs_data(rs_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_npc(input logic [31:0] cur, input logic [31:0] instr,
                                            input logic nps, input logic jj, input logic jl,
                                            input logic jrr, input logic br,
                                            input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4  = cur + 32'd4;
        off = int'($signed(instr[15:0])) * 4;
        if (jrr)           return rs & 32'hFFFF_FFFC;
        if (jj || jl)      return (p4 & 32'hF000_0000) | ({6'b0, instr[25:0]} << 2);
        if (nps && br)     return p4 + 32'(off);
        return p4;
    endfunction

    logic        m_init = 1'b0;
    logic [31:0] m_pc, m_ir;
    logic        m_valid, m_req, m_mis;

    // Model: while no instruction is held, a request is outstanding (raised
    // the cycle after entering fetch) and the first ready during it delivers
    // the word; while one is held, commit moves pc and restarts fetch.
    always @(posedge clk) begin
        if (reset) begin
            m_init = 1'b1; m_pc = RST_PC; m_ir = '0;
            m_valid = 1'b0; m_req = 1'b0; m_mis = 1'b0;
        end else if (m_init) begin
            m_mis = 1'b0;
            if (m_valid) begin
                if (commit) begin
                    m_mis   = jr && (rs_data[1:0] != 2'b00);
                    m_pc    = ref_npc(m_pc, m_ir, nPC_sel, J, jal, jr, br_taken, rs_data);
                    m_valid = 1'b0;
                    m_req   = 1'b1;
                end
            end else if (m_req && imem_ready) begin
                m_ir = imem_rdata; m_valid = 1'b1; m_req = 1'b0;
            end else begin
                m_req = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("ir", ir, m_ir);
            chk("imem_req", 32'(imem_req), 32'(m_req));
            chk("misalign", 32'(misalign), 32'(m_mis));
            if (m_req) chk("imem_addr", imem_addr, m_pc);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin step(); n++; end
        if (!imem_req) chk("req_timeout", 32'(imem_req), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input int dly);
        wait_req();
        chk("fetch_addr", imem_addr, addr);
        repeat (dly) step();
        imem_rdata = word; imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        chk("fetch_valid", 32'(ir_valid), 32'd1);
        chk("fetch_ir", ir, word);
    endtask

    task automatic do_commit(input logic nps, input logic jj, input logic jl, input logic jrr,
                             input logic br, input logic [31:0] rs);
        nPC_sel = nps; J = jj; jal = jl; jr = jrr; br_taken = br; rs_data = rs;
        commit = 1'b1;
        step();
        commit = 1'b0; nPC_sel = 0; J = 0; jal = 0; jr = 0; br_taken = 0;
        chk("req_after_commit", 32'(imem_req), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (2) step();
        chk("rst_pc", pc, RST_PC);
        chk("rst_ir", ir, 32'd0);
        chk("rst_valid", 32'(ir_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        reset = 1'b0;

        fetch(32'h3000, W_ADDU, 2);
        chk("pc_3000", pc, 32'h3000);
        do_commit(0, 0, 0, 0, 0, 0);
        chk("addr_3004", imem_addr, 32'h3004);

        fetch(32'h3004, 32'h0, 0);
        do_commit(0, 0, 0, 0, 0, 0);
        fetch(32'h3008, W_BEQ, 1);
        do_commit(1, 0, 0, 0, 1, 0);
        chk("beq_taken", pc, 32'h3008);
        fetch(32'h3008, W_BEQ, 0);
        do_commit(1, 0, 0, 0, 0, 0);
        chk("beq_not_taken", pc, 32'h300C);
        fetch(32'h300C, 32'h0, 1);
        do_commit(0, 0, 0, 0, 0, 0);

        fetch(32'h3010, W_JAL, 3);
        chk("jal_link", pc_plus4, 32'h3014);
        do_commit(1, 0, 1, 0, 1, 0);
        chk("jal_target", pc, 32'h3040);

        fetch(32'h3040, W_JR, 0);
        do_commit(0, 0, 0, 1, 0, 32'h0000_3022);
        chk("jr_target", pc, 32'h3020);
        chk("jr_misalign", 32'(misalign), 32'd1);
        step();
        chk("misalign_pulse_end", 32'(misalign), 32'd0);

        // reset while waiting for memory; the late response must be dropped
        wait_req();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        chk("rstwait_pc", pc, RST_PC);
        chk("rstwait_ir", ir, 32'd0);
        chk("rstwait_valid", 32'(ir_valid), 32'd0);
        step();
        imem_ready = 1'b0;
        chk("stale_dropped", 32'(ir_valid), 32'd0);
        chk("fresh_req", 32'(imem_req), 32'd1);
        chk("fresh_addr", imem_addr, 32'h3000);

        // wrap-around at the top of the address space
        fetch(32'h3000, W_JR, 1);
        do_commit(0, 0, 0, 1, 0, 32'hFFFF_FFFC);
        chk("jr_top", pc, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0, 0);
        chk("wrap_pc4", pc_plus4, 32'h0);
        do_commit(0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            imem_ready = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            commit     = ($urandom_range(0, 2) == 0);
            nPC_sel    = $urandom_range(0, 1) == 1;
            br_taken   = $urandom_range(0, 1) == 1;
            J          = $urandom_range(0, 3) == 0;
            jal        = $urandom_range(0, 3) == 0;
            jr         = $urandom_range(0, 3) == 0;
            rs_data    = $urandom;
            if ($urandom_range(0, 1) == 1) rs_data[1:0] = 2'b00;
            step();
        end
        reset = 0; commit = 0; imem_ready = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
